// File: rtl/exu_muldiv_pipeline.sv
// RV32M multiply/divide unit: registered multiply, radix-2 restoring divide.
// Define EXU_MULDIV_EARLY_OUT_EN for single-cycle trivial divides.
module exu_muldiv_pipeline #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [1:0]        f3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   dvd_q;
  logic [XLEN-1:0]   dvs_q;
  logic [XLEN:0]     rem_q;
  logic [2*XLEN-1:0] prod_q;
  logic              q_neg_q;
  logic              r_neg_q;
  logic              dz_q;
  logic              ovf_q;
  logic              div_early;

  logic accept;
  assign in_ready = (state == IDLE) && !flush;
  assign accept   = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // operand conditioning at accept
  logic            sgn_div;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            is_dz;
  logic            is_ovf;
  logic            sa;
  logic            sb;
  logic [2*XLEN-1:0] ext_a;
  logic [2*XLEN-1:0] ext_b;

  assign sgn_div = !in_funct3[0];
  assign a_neg   = sgn_div && in_a[XLEN-1];
  assign b_neg   = sgn_div && in_b[XLEN-1];
  assign abs_a   = a_neg ? -in_a : in_a;
  assign abs_b   = b_neg ? -in_b : in_b;
  assign is_dz   = (in_b == '0);
  assign is_ovf  = sgn_div && (in_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (in_b == '1);

  assign sa    = (in_funct3[1:0] == 2'b01) || (in_funct3[1:0] == 2'b10);
  assign sb    = (in_funct3[1:0] == 2'b01);
  assign ext_a = {{XLEN{sa && in_a[XLEN-1]}}, in_a};
  assign ext_b = {{XLEN{sb && in_b[XLEN-1]}}, in_b};

`ifdef EXU_MULDIV_EARLY_OUT_EN
  logic small_q;
  assign div_early = dz_q || ovf_q || small_q;
`else
  assign div_early = 1'b0;
`endif

  // one restoring step: shift in next dividend bit, try subtract
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  assign shifted = {rem_q[XLEN-1:0], dvd_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] div_res;

  always_comb begin
    q_fix = q_neg_q ? -dvd_q : dvd_q;
    r_fix = r_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    if (dz_q) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (ovf_q) begin
      q_fix = a_q;
      r_fix = '0;
    end
`ifdef EXU_MULDIV_EARLY_OUT_EN
    else if (small_q) begin
      q_fix = '0;
      r_fix = a_q;
    end
`endif
  end

  assign mul_res = (f3_q == 2'b00) ? prod_q[XLEN-1:0]
                                   : prod_q[2*XLEN-1:XLEN];
  assign div_res = f3_q[1] ? r_fix : q_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = in_funct3[2] ? DIV : MUL;
      MUL:  if (cnt == MUL_LAST) state_nx = DONE;
      DIV:  if (cnt == DIV_LAST || div_early) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      prod_q     <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
`ifdef EXU_MULDIV_EARLY_OUT_EN
      small_q    <= 1'b0;
`endif
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          cnt     <= '0;
          f3_q    <= in_funct3[1:0];
          rd_q    <= in_rd;
          a_q     <= in_a;
          dvd_q   <= abs_a;
          dvs_q   <= abs_b;
          rem_q   <= '0;
          prod_q  <= ext_a * ext_b;
          q_neg_q <= a_neg ^ b_neg;
          r_neg_q <= a_neg;
          dz_q    <= is_dz;
          ovf_q   <= is_ovf;
`ifdef EXU_MULDIV_EARLY_OUT_EN
          small_q <= (abs_a < abs_b);
`endif
        end
        MUL: begin
          if (state_nx == DONE) begin
            cnt        <= '0;
            out_result <= mul_res;
            out_rd     <= rd_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (state_nx == DONE) begin
            cnt        <= '0;
            out_result <= div_res;
            out_rd     <= rd_q;
          end else begin
            cnt   <= cnt + 1'b1;
            rem_q <= trial[XLEN] ? shifted : trial;
            dvd_q <= {dvd_q[XLEN-2:0], !trial[XLEN]};
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/exu_muldiv_pipeline.md
Name: exu_muldiv_pipeline

Overview:
- Multi-cycle RV32M execution unit. It sits beside the single-cycle ALU in the EX stage and is fed from the ID/EX register.
- Executes MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU behind a valid/ready handshake. Holds the result in an output register until the EX/MEM side accepts it.
- Operand width and multiply latency are parametrised. Division is iterative restoring, radix-2.

Parameters:
- XLEN, 32, operand/result width (>=8, even).
- MUL_LATENCY, 3, cycles from accept to out_valid for multiply ops (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  abort in-flight op and drop any held result
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_funct3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_a  in  XLEN  rs1 value
- in_b  in  XLEN  rs2 value
- in_rd  in  5  destination register
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts
- out_result  out  XLEN  result
- out_rd  out  5  destination register of the result
- busy  out  1  state != IDLE (for hazard stall logic)

Behaviour:
- Clock/reset: single clock clk. rst is asynchronous, active-high, and forces state=IDLE and all counters 0. All outputs reset as follows: out_valid=0, out_result=0, out_rd=0, busy=0, in_ready=1.
- States:
  - IDLE -> MUL on accept with funct3[2]=0.
  - IDLE -> DIV on accept with funct3[2]=1.
  - MUL -> DONE when the latency counter reaches MUL_LATENCY-1.
  - DIV -> DONE after XLEN iterations.
  - DONE -> IDLE on out_valid && out_ready.
- in_ready = (state==IDLE) && !flush. Accept = in_valid && in_ready. Accept latches funct3, rd and operands.
- Multiply:
  - The 2*XLEN product is formed from sign-extended operands: signed x signed for MULH, signed x unsigned for MULHSU, unsigned x unsigned for MULHU/MUL.
  - It is registered on accept and held while a counter runs.
  - MUL returns the low XLEN bits. MULH* return the high XLEN bits.
  - out_valid rises exactly MUL_LATENCY cycles after the accept edge.
- Divide:
  - On accept, latch |a| and |b| (signed ops) or a and b (unsigned ops). Record the quotient sign (a^b sign) and the remainder sign (a sign).
  - XLEN restoring iterations, one per cycle, over a XLEN+1-bit partial remainder.
  - Sign fixup in the DONE transition.
  - out_valid rises XLEN+1 cycles after the accept edge (33 for XLEN=32).
- Divide corner cases (RISC-V spec):
  - b==0: quotient = all ones; remainder = a.
  - Signed overflow (a = most-negative, b = -1): quotient = a; remainder = 0.
  - These results are produced regardless of timing path.
- Output handshake:
  - In DONE, out_valid=1 and out_result/out_rd are stable until the handshake.
  - The handshake cycle returns to IDLE. A new accept is possible the following cycle, so there is no same-cycle back-to-back issue.
  - out_ready high before DONE has no effect.
- Flush:
  - Synchronous. Highest priority over accept and the output handshake.
  - Next state is IDLE; out_valid=0 next cycle; counters cleared.
  - No result from the aborted op is ever presented.
- Reset mid-operation: immediate abort, with the same end state as reset.
- Width: the counter is clog2(XLEN)+1 bits. No truncation warnings are permitted.

Optional Feature:
- Macro EXU_MULDIV_EARLY_OUT_EN.
- Defined:
  - DIV/REM with b==0 or signed overflow skip iteration, and out_valid rises 1 cycle after accept.
  - Unsigned/abs dividend < divisor also finishes in 1 cycle: quotient 0, remainder a.
- Undefined: every divide takes the full XLEN+1 cycles. Results are identical in both cases.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD), out_ready=1 -> out_result=0xFFFFFFEB exactly 3 cycles after accept; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV a=-20, b=3 -> 0xFFFFFFFA (-6); REM -> 0xFFFFFFFE (-2); DIVU a=20, b=3 -> 6, valid 33 cycles after accept.
- DIV a=5, b=0 -> 0xFFFFFFFF and REM -> 5. DIV a=0x80000000, b=-1 -> 0x80000000 and REM -> 0. Latency is 33 without the macro and 1 with it.
- Backpressure: hold out_ready=0 for 10 cycles after DONE -> out_valid, out_result and out_rd stable, in_ready=0, busy=1. Then raise out_ready -> in_ready=1 on the next cycle.
- Flush at iteration 10 of a DIV -> out_valid never asserts. A MUL issued 2 cycles later returns the correct result with no stale data.
- Assert rst asynchronously mid-MUL -> outputs go to reset values immediately, without waiting for a clock edge. After release, a DIVU 100/7 returns 14.
